// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M unit: MUL/MULH/MULHSU/MULHU and DIV/DIVU/REM/REMU beside the integer execute stage.
// Latency: MUL family 2 cycles, divide XLEN+2 cycles, divide-by-zero/overflow 1 cycle.
// Backpressure: stall_req holds the pipeline while iterating; start is ignored while busy; flush aborts to IDLE.
//
// Ports:
//   clk, rst_n (synchronous, active-low)
//   start, funct3, operand1, operand2, rd  - issue request and its operands
//   flush                                  - abort whatever is in flight
//   busy, stall_req                        - pipeline hold indications
//   regs_write_en/addr/data                - one-cycle result strobe in DONE
module ex_muldiv #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [XLEN-1:0]       operand1,
    input  logic [XLEN-1:0]       operand2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  flush,
    output logic                  busy,
    output logic                  stall_req,
    output logic                  regs_write_en,
    output logic [REG_ADDR_W-1:0] regs_write_addr,
    output logic [XLEN-1:0]       regs_write_data
);

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_DIV  = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    logic [2:0]            state_q, state_d;
    // op_a holds operand1 for multiplies and the dividend/quotient shift register for divides;
    // op_b holds operand2 for multiplies and the (absolute) divisor for divides.
    logic [XLEN-1:0]       op_a_q, op_a_d;
    logic [XLEN-1:0]       op_b_q, op_b_d;
    logic [XLEN-1:0]       rem_q, rem_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    // Only funct3[1:0] is needed after issue: funct3[2] is already encoded in the MUL/DIV state.
    logic [1:0]            f3_q, f3_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  qsign_q, qsign_d;
    logic                  rsign_q, rsign_d;

    logic                  accept;
    logic                  div_signed;
    logic                  sign1, sign2;
    logic [XLEN-1:0]       abs1, abs2;

    logic                  a_signed, b_signed;
    logic [2*XLEN-1:0]     a_wide, b_wide, prod;

    logic [XLEN:0]         shifted;
    logic                  step_ok;
    logic [XLEN-1:0]       step_diff;

    logic [XLEN-1:0]       quot_fix, rem_fix;
    logic                  in_done;

    assign accept = start & ~flush & ((state_q == ST_IDLE) | (state_q == ST_DONE));

    // Issue-time operand conditioning for divides.
    assign div_signed = ~funct3[0];
    assign sign1      = div_signed & operand1[XLEN-1];
    assign sign2      = div_signed & operand2[XLEN-1];
    assign abs1       = sign1 ? -operand1 : operand1;
    assign abs2       = sign2 ? -operand2 : operand2;

    // Multiplier: sign/zero-extend to 2*XLEN; the low 2*XLEN bits of the product are exact
    // for every signedness combination.
    assign a_signed = f3_q[0] ^ f3_q[1];          // MULH, MULHSU
    assign b_signed = (f3_q == 2'b01);            // MULH only
    assign a_wide   = {{XLEN{a_signed & op_a_q[XLEN-1]}}, op_a_q};
    assign b_wide   = {{XLEN{b_signed & op_b_q[XLEN-1]}}, op_b_q};
    assign prod     = a_wide * b_wide;

    // Restoring divide step. The shifted partial remainder can reach 2*divisor-1, so it
    // carries one extra bit; after a successful subtract the difference is below the divisor
    // and fits in XLEN bits.
    assign shifted   = {rem_q, op_a_q[XLEN-1]};
    assign step_ok   = (shifted >= {1'b0, op_b_q});
    assign step_diff = shifted[XLEN-1:0] - op_b_q;

    assign quot_fix = qsign_q ? -op_a_q : op_a_q;
    assign rem_fix  = rsign_q ? -rem_q  : rem_q;

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        rem_d    = rem_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    f3_d = funct3[1:0];
                    rd_d = rd;
                    if (!funct3[2]) begin
                        op_a_d  = operand1;
                        op_b_d  = operand2;
                        state_d = ST_MUL;
                    end else if (operand2 == '0) begin
                        result_d = funct3[1] ? operand1 : ALL_ONES;
                        state_d  = ST_DONE;
                    end else if (div_signed && (operand1 == MOST_NEG) && (operand2 == ALL_ONES)) begin
                        result_d = funct3[1] ? '0 : MOST_NEG;
                        state_d  = ST_DONE;
                    end else begin
                        op_a_d  = abs1;
                        op_b_d  = abs2;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(XLEN - 1);
                        qsign_d = sign1 ^ sign2;
                        rsign_d = sign1;
                        state_d = ST_DIV;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                result_d = (f3_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                state_d  = ST_DONE;
            end
            ST_DIV: begin
                op_a_d = {op_a_q[XLEN-2:0], step_ok};
                rem_d  = step_ok ? step_diff : shifted[XLEN-1:0];
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FIX: begin
                result_d = f3_q[1] ? rem_fix : quot_fix;
                state_d  = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            rem_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
        end
    end

    // Outputs are gated by rst_n so they read zero for the whole time reset is held,
    // not only after the first reset edge.
    assign busy            = rst_n & ((state_q == ST_MUL) | (state_q == ST_DIV) | (state_q == ST_FIX));
    assign in_done         = rst_n & (state_q == ST_DONE);
    assign stall_req       = busy | (start & ~flush);
    assign regs_write_en   = in_done;
    assign regs_write_addr = in_done ? rd_q : '0;
    assign regs_write_data = in_done ? result_q : '0;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] operand1 = '0;
    logic [31:0] operand2 = '0;
    logic [4:0]  rd = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        stall_req;
    logic        regs_write_en;
    logic [4:0]  regs_write_addr;
    logic [31:0] regs_write_data;

    int n_tests = 0;
    int n_fail  = 0;

    ex_muldiv #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .funct3          (funct3),
        .operand1        (operand1),
        .operand2        (operand2),
        .rd              (rd),
        .flush           (flush),
        .busy            (busy),
        .stall_req       (stall_req),
        .regs_write_en   (regs_write_en),
        .regs_write_addr (regs_write_addr),
        .regs_write_data (regs_write_data)
    );

    always #5 clk = ~clk;

    // Present an op in the current cycle (cycle 0), let the edge accept it, then scramble inputs.
    // Entered and left 1 time unit after a rising edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, output logic st0);
        start    = 1'b1;
        funct3   = f3;
        operand1 = a;
        operand2 = b;
        rd       = r;
        #1 st0 = stall_req;
        @(posedge clk); #1;
        start    = 1'b0;
        funct3   = 3'b011;
        operand1 = 32'hA5A5_5A5A;
        operand2 = 32'h0F0F_F0F0;
        rd       = 5'd31;
    endtask

    // Issue and wait (bounded) for the write strobe; returns in the DONE cycle.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, output int lat, output logic [31:0] data,
                         output logic [4:0] addr, output int busy_n, output logic st0);
        issue(f3, a, b, r, st0);
        lat = -1; data = '0; addr = '0; busy_n = 0;
        for (int c = 1; c <= 100; c++) begin
            if (regs_write_en) begin
                lat = c; data = regs_write_data; addr = regs_write_addr;
                break;
            end
            if (busy) busy_n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, regs_write_en, regs_write_addr, regs_write_data, stall_req} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b en=%b addr=%h data=%h stall=%b, expected all 0",
                     busy, regs_write_en, regs_write_addr, regs_write_data, stall_req);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || regs_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b en=%b, expected 0 0", busy, regs_write_en);
        end
    endtask

    task automatic test_mul();
        logic [2:0]  f3  [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
        logic [31:0] av  [4] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] bv  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'd2};
        logic [31:0] exp [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF};
        int lat, busy_n; logic [31:0] data; logic [4:0] addr; logic st0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            do_op(f3[i], av[i], bv[i], 5'(i + 1), lat, data, addr, busy_n, st0);
            n_tests++;
            if (lat !== 2 || data !== exp[i] || addr !== 5'(i + 1) || busy_n !== 1 || st0 !== 1'b1) begin
                n_fail++;
                $display("FAIL mul[%0d]: got lat=%0d data=%h rd=%0d busy_cycles=%0d stall0=%b, expected lat=2 data=%h rd=%0d busy_cycles=1 stall0=1",
                         i, lat, data, addr, busy_n, st0, exp[i], i + 1);
            end
            n_tests++;
            if (busy !== 1'b0 || stall_req !== 1'b0) begin
                n_fail++;
                $display("FAIL mul_done_flags[%0d]: got busy=%b stall=%b, expected 0 0", i, busy, stall_req);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  f3  [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] av  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                 32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bv  [8] = '{32'd2, 32'd2, 32'd7, 32'd7,
                                 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [31:0] exp [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                 32'hFFFF_FFFD, 32'd1, 32'd1, 32'd1};
        int lat, busy_n; logic [31:0] data; logic [4:0] addr; logic st0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            do_op(f3[i], av[i], bv[i], 5'(i + 10), lat, data, addr, busy_n, st0);
            n_tests++;
            if (lat !== 34 || data !== exp[i] || addr !== 5'(i + 10) || busy_n !== 33) begin
                n_fail++;
                $display("FAIL div[%0d]: got lat=%0d data=%h rd=%0d busy_cycles=%0d, expected lat=34 data=%h rd=%0d busy_cycles=33",
                         i, lat, data, addr, busy_n, exp[i], i + 10);
            end
        end
    endtask

    task automatic test_div_special();
        logic [2:0]  f3  [5] = '{3'b101, 3'b110, 3'b100, 3'b110, 3'b101};
        logic [31:0] av  [5] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv  [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [5] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0};
        int          elat[5] = '{1, 1, 1, 1, 34};
        int lat, busy_n; logic [31:0] data; logic [4:0] addr; logic st0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            do_op(f3[i], av[i], bv[i], 5'(i + 20), lat, data, addr, busy_n, st0);
            n_tests++;
            if (lat !== elat[i] || data !== exp[i] || addr !== 5'(i + 20)) begin
                n_fail++;
                $display("FAIL div_special[%0d]: got lat=%0d data=%h rd=%0d, expected lat=%0d data=%h rd=%0d",
                         i, lat, data, addr, elat[i], exp[i], i + 20);
            end
        end
    endtask

    task automatic test_flush();
        logic st0;
        int   seen;
        @(posedge clk); #1;
        issue(3'b101, 32'd100, 32'd7, 5'd3, st0);
        repeat (9) begin @(posedge clk); #1; end
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre_busy: got busy=%b, expected 1", busy);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: got busy=%b stall=%b, expected 0 0", busy, stall_req);
        end
        seen = 0;
        repeat (40) begin
            if (regs_write_en) seen++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL flush_no_write: got %0d strobes, expected 0", seen);
        end
        // start together with flush must be dropped
        start = 1'b1; flush = 1'b1; funct3 = 3'b000; operand1 = 32'd2; operand2 = 32'd2; rd = 5'd4;
        #1;
        n_tests++;
        if (stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_start_stall: got stall=%b, expected 0", stall_req);
        end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        seen = 0;
        repeat (3) begin
            if (busy || regs_write_en) seen++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL flush_start_ignored: got %0d busy/strobe cycles, expected 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int lat, busy_n, seen; logic [31:0] data; logic [4:0] addr; logic st0;
        @(posedge clk); #1;
        issue(3'b100, 32'd1000, 32'd3, 5'd6, st0);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || regs_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_low: got busy=%b en=%b, expected 0 0", busy, regs_write_en);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            if (busy || regs_write_en || regs_write_addr != 0 || regs_write_data != 0) seen++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_idle: got %0d non-idle cycles, expected 0", seen);
        end
        do_op(3'b000, 32'd3, 32'd4, 5'd9, lat, data, addr, busy_n, st0);
        n_tests++;
        if (lat !== 2 || data !== 32'd12 || addr !== 5'd9) begin
            n_fail++;
            $display("FAIL rst_mid_mul: got lat=%0d data=%h rd=%0d, expected lat=2 data=0000000c rd=9",
                     lat, data, addr);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(posedge clk); #1;
        @(posedge clk); #1;
        // cycle 0: MUL 2*3
        start = 1'b1; funct3 = 3'b000; operand1 = 32'd2; operand2 = 32'd3; rd = 5'd5;
        @(posedge clk); #1;
        // cycle 1: busy; start held with the next op, must be ignored here
        funct3 = 3'b101; operand1 = 32'd9; operand2 = 32'd3; rd = 5'd7;
        n_tests++;
        if (busy !== 1'b1 || stall_req !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_busy: got busy=%b stall=%b, expected 1 1", busy, stall_req);
        end
        @(posedge clk); #1;
        // cycle 2: DONE of MUL, start accepted here
        n_tests++;
        if (regs_write_en !== 1'b1 || regs_write_data !== 32'd6 || regs_write_addr !== 5'd5 || stall_req !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got en=%b data=%h rd=%0d stall=%b, expected en=1 data=00000006 rd=5 stall=1",
                     regs_write_en, regs_write_data, regs_write_addr, stall_req);
        end
        @(posedge clk); #1;
        start = 1'b0; operand1 = 32'hFFFF_0000; operand2 = 32'd1; rd = 5'd0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_no_bubble: got busy=%b in cycle 3, expected 1", busy);
        end
        lat = -1;
        for (int c = 3; c <= 100; c++) begin
            if (regs_write_en) begin lat = c; break; end
            @(posedge clk); #1;
        end
        n_tests++;
        if (lat !== 36 || regs_write_data !== 32'd3 || regs_write_addr !== 5'd7) begin
            n_fail++;
            $display("FAIL b2b_second: got cycle=%0d data=%h rd=%0d, expected cycle=36 data=00000003 rd=7",
                     lat, regs_write_data, regs_write_addr);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
